// File: rtl/minimig_sram_arbiter.sv
// Slot sequencer sharing the external async 16-bit SRAM between the chipset
// bus and a host port. Chipset has absolute priority; the host gets any slot
// the chipset leaves free. All SRAM strobes are registered and phase-aligned
// to the c1/c3 enables (Q0..Q3 = one 4-clk slot).
module minimig_sram_arbiter #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic            clk,
    input  logic            _reset,
    input  logic            c1,
    input  logic            c3,
    input  logic            chip_sel,
    input  logic [ADDR_W:1] chip_addr,
    input  logic            chip_rd,
    input  logic            chip_hwr,
    input  logic            chip_lwr,
    input  logic [15:0]     chip_wdata,
    output logic [15:0]     chip_rdata,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [1:0]      host_be,
    input  logic [ADDR_W:1] host_addr,
    input  logic [15:0]     host_wdata,
    output logic [15:0]     host_rdata,
    output logic            host_ack,
    output logic            host_starved,
    output logic [ADDR_W:1] sram_addr,
    output logic [15:0]     sram_dout,
    input  logic [15:0]     sram_din,
    output logic            _sram_we,
    output logic            _sram_oe,
    output logic            _sram_bhe,
    output logic            _sram_ble
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHIP = 2'd1,
        HOST = 2'd2
    } state_t;

    state_t           state;
    logic             slot_write;
    logic             ack_pending;
    logic [CNT_W-1:0] wait_cnt;

    logic             q0_c;
    logic             q1_c;
    logic             q2_c;
    logic             q3_c;
    logic             chip_req_c;
    logic             host_win_c;
    logic [CNT_W-1:0] wait_cnt_next_c;

    // Phase decode, grant decision and starvation counter update for the Q1 edge
    always_comb begin
        q0_c            = !c1 && !c3;
        q1_c            =  c1 && !c3;
        q2_c            =  c1 &&  c3;
        q3_c            = !c1 &&  c3;
        chip_req_c      = chip_sel && (chip_rd || chip_hwr || chip_lwr);
        host_win_c      = !chip_req_c && host_req && !ack_pending;
        wait_cnt_next_c = wait_cnt;
        if (host_req && chip_req_c) begin
            if (wait_cnt != CNT_MAX) begin
                wait_cnt_next_c = wait_cnt + CNT_W'(1);
            end
        end else if (host_win_c || !host_req) begin
            wait_cnt_next_c = '0;
        end
    end

    // Slot state machine: grant at Q1, write strobe at Q2, read capture at Q3, release at Q0
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state        <= IDLE;
            slot_write   <= 1'b0;
            ack_pending  <= 1'b0;
            wait_cnt     <= '0;
            chip_rdata   <= '0;
            host_rdata   <= '0;
            host_ack     <= 1'b0;
            host_starved <= 1'b0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            _sram_we     <= 1'b1;
            _sram_oe     <= 1'b1;
            _sram_bhe    <= 1'b1;
            _sram_ble    <= 1'b1;
        end else begin
            host_ack <= 1'b0;
            if (q1_c) begin
                ack_pending  <= 1'b0;
                wait_cnt     <= wait_cnt_next_c;
                host_starved <= (wait_cnt_next_c == CNT_MAX);
                if (chip_req_c) begin
                    state      <= CHIP;
                    slot_write <= !chip_rd;
                    sram_addr  <= chip_addr;
                    sram_dout  <= chip_wdata;
                    _sram_oe   <= !chip_rd;
                    _sram_bhe  <= !(chip_rd || chip_hwr);
                    _sram_ble  <= !(chip_rd || chip_lwr);
                end else if (host_win_c) begin
                    state      <= HOST;
                    slot_write <= host_we;
                    sram_addr  <= host_addr;
                    sram_dout  <= host_wdata;
                    _sram_oe   <= host_we;
                    _sram_bhe  <= host_we && !host_be[1];
                    _sram_ble  <= host_we && !host_be[0];
                end
            end else if (q2_c) begin
                chip_rdata <= '0;
                // A write with no byte lane enabled still uses the slot but never pulses we
                if (slot_write && !(_sram_bhe && _sram_ble)) begin
                    _sram_we <= 1'b0;
                end
            end else if (q3_c) begin
                if (state == CHIP && !slot_write) begin
                    chip_rdata <= sram_din;
                end
                if (state == HOST && !slot_write) begin
                    host_rdata <= sram_din;
                end
            end else if (q0_c) begin
                state       <= IDLE;
                slot_write  <= 1'b0;
                _sram_we    <= 1'b1;
                _sram_oe    <= 1'b1;
                _sram_bhe   <= 1'b1;
                _sram_ble   <= 1'b1;
                // Pending blocks the host from re-winning the very next Q1
                ack_pending <= (state == HOST);
                if (state == HOST) begin
                    host_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_minimig_sram_arbiter.sv
// Bench for minimig_sram_arbiter: slot-level reference model (winner per
// slot, expected strobe pattern per phase, expected memory contents) plus a
// pin-level SRAM model driven by the DUT strobes.
module tb_minimig_sram_arbiter;

    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned WAIT_LIMIT = 15;
    localparam logic [ADDR_W:1] BASE   = 22'h12340;

    logic            clk = 1'b0;
    logic            _reset;
    logic            c1, c3;
    logic            chip_sel;
    logic [ADDR_W:1] chip_addr;
    logic            chip_rd, chip_hwr, chip_lwr;
    logic [15:0]     chip_wdata;
    logic [15:0]     chip_rdata;
    logic            host_req, host_we;
    logic [1:0]      host_be;
    logic [ADDR_W:1] host_addr;
    logic [15:0]     host_wdata;
    logic [15:0]     host_rdata;
    logic            host_ack, host_starved;
    logic [ADDR_W:1] sram_addr;
    logic [15:0]     sram_dout, sram_din;
    logic            _sram_we, _sram_oe, _sram_bhe, _sram_ble;

    always #5 clk = ~clk;

    minimig_sram_arbiter #(.ADDR_W(ADDR_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), ._reset(_reset), .c1(c1), .c3(c3),
        .chip_sel(chip_sel), .chip_addr(chip_addr), .chip_rd(chip_rd),
        .chip_hwr(chip_hwr), .chip_lwr(chip_lwr), .chip_wdata(chip_wdata),
        .chip_rdata(chip_rdata),
        .host_req(host_req), .host_we(host_we), .host_be(host_be),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ack(host_ack), .host_starved(host_starved),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        ._sram_we(_sram_we), ._sram_oe(_sram_oe), ._sram_bhe(_sram_bhe), ._sram_ble(_sram_ble)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ack_cyc;
    int last_win;

    logic [15:0] sram_mem [16];
    logic [15:0] exp_mem  [16];

    // reference model state
    logic            m_ack_pend;
    int              m_cnt;
    logic [ADDR_W:1] m_addr;
    logic [15:0]     m_dout, m_hrdata, m_crdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int win_idx(input logic [ADDR_W:1] a);
        if (a >= BASE && a < BASE + 22'd16) return int'(a - BASE);
        return -1;
    endfunction

    task automatic set_phase(input int q);
        c1 = (q == 1 || q == 2);
        c3 = (q == 2 || q == 3);
    endtask

    // one clock; then the SRAM pin model reacts to the new strobes
    task automatic step();
        int idx;
        @(posedge clk);
        #1;
        cyc++;
        idx = win_idx(sram_addr);
        if (!_sram_we && idx >= 0) begin
            if (!_sram_bhe) sram_mem[idx][15:8] = sram_dout[15:8];
            if (!_sram_ble) sram_mem[idx][7:0]  = sram_dout[7:0];
        end
        sram_din = (idx >= 0) ? sram_mem[idx] : 16'h0000;
    endtask

    task automatic model_reset();
        m_ack_pend = 1'b0;
        m_cnt      = 0;
        m_addr     = '0;
        m_dout     = '0;
        m_hrdata   = '0;
        m_crdata   = '0;
        last_win   = 0;
    endtask

    task automatic set_chip(input logic sel, input logic rd, input logic hwr, input logic lwr,
                            input logic [ADDR_W:1] a, input logic [15:0] d);
        chip_sel = sel; chip_rd = rd; chip_hwr = hwr; chip_lwr = lwr;
        chip_addr = a; chip_wdata = d;
    endtask

    task automatic host_new();
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_be    = 2'($urandom_range(0, 3));
        host_addr  = BASE + 22'($urandom_range(0, 15));
        host_wdata = 16'($urandom);
    endtask

    // mid-slot noise on every request input; the design must ignore it
    task automatic glitch_inputs();
        set_chip(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 22'($urandom), 16'($urandom));
        host_req   = 1'($urandom);
        host_we    = 1'($urandom);
        host_be    = 2'($urandom);
        host_addr  = 22'($urandom);
        host_wdata = 16'($urandom);
    endtask

    // one full slot Q1,Q2,Q3,Q0 with the current inputs presented at Q1
    task automatic run_slot();
        int              win;
        int              idx;
        logic            rd, e_we, e_oe;
        logic [1:0]      be;
        logic [15:0]     rdval;
        logic            sv_req, sv_we;
        logic [1:0]      sv_be;
        logic [ADDR_W:1] sv_addr;
        logic [15:0]     sv_wd;

        win = 0; rd = 1'b0; be = 2'b00;
        if (chip_sel && (chip_rd || chip_hwr || chip_lwr)) win = 1;
        else if (host_req && !m_ack_pend) win = 2;
        if (win == 1) begin
            rd = chip_rd; be = chip_rd ? 2'b11 : {chip_hwr, chip_lwr};
            m_addr = chip_addr; m_dout = chip_wdata;
        end else if (win == 2) begin
            rd = !host_we; be = host_we ? host_be : 2'b11;
            m_addr = host_addr; m_dout = host_wdata;
        end
        if (host_req && win == 1) m_cnt = (m_cnt < WAIT_LIMIT) ? m_cnt + 1 : m_cnt;
        else if (win == 2 || !host_req) m_cnt = 0;
        idx   = win_idx(m_addr);
        rdval = (idx >= 0) ? exp_mem[idx] : 16'h0000;
        if (win != 0 && !rd && idx >= 0) begin
            if (be[1]) exp_mem[idx][15:8] = m_dout[15:8];
            if (be[0]) exp_mem[idx][7:0]  = m_dout[7:0];
        end
        e_we = !(win != 0 && !rd && be != 2'b00);
        e_oe = !(win != 0 && rd);

        sv_req = host_req; sv_we = host_we; sv_be = host_be; sv_addr = host_addr; sv_wd = host_wdata;

        set_phase(1); step();
        check_eq("q1_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'({1'b1, e_oe, !be[1], !be[0]}));
        check_eq("q1_addr", 32'(sram_addr), 32'(m_addr));
        check_eq("q1_dout", 32'(sram_dout), 32'(m_dout));
        check_eq("q1_ack", 32'(host_ack), 32'd0);
        check_eq("q1_starved", 32'(host_starved), 32'(m_cnt == WAIT_LIMIT));
        check_eq("q1_crdata", 32'(chip_rdata), 32'(m_crdata));

        glitch_inputs();
        set_phase(2); step();
        m_crdata = '0;
        check_eq("q2_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'({e_we, e_oe, !be[1], !be[0]}));
        check_eq("q2_crdata", 32'(chip_rdata), 32'(m_crdata));

        glitch_inputs();
        set_phase(3); step();
        if (win == 1 && rd) m_crdata = rdval;
        if (win == 2 && rd) m_hrdata = rdval;
        check_eq("q3_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'({e_we, e_oe, !be[1], !be[0]}));
        check_eq("q3_crdata", 32'(chip_rdata), 32'(m_crdata));
        check_eq("q3_addr", 32'(sram_addr), 32'(m_addr));

        host_req = sv_req; host_we = sv_we; host_be = sv_be; host_addr = sv_addr; host_wdata = sv_wd;
        set_phase(0); step();
        check_eq("q0_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'hF);
        check_eq("q0_ack", 32'(host_ack), 32'(win == 2));
        check_eq("q0_hrdata", 32'(host_rdata), 32'(m_hrdata));
        check_eq("q0_crdata", 32'(chip_rdata), 32'(m_crdata));
        check_eq("q0_addr", 32'(sram_addr), 32'(m_addr));
        if (host_ack) last_ack_cyc = cyc;
        m_ack_pend = (win == 2);
        last_win   = win;
    endtask

    // run slots until the host wins (bounded), then drop the request
    task automatic host_until_ack(input string tag);
        int n = 0;
        last_win = 0;
        while (last_win != 2 && n < 4) begin
            run_slot();
            n++;
        end
        check_eq(tag, 32'(last_win), 32'd2);
        host_req = 1'b0;
    endtask

    initial begin
        int s;
        int chip_pct;
        int kind;
        logic [15:0] old;

        _reset = 1'b0;
        set_phase(0);
        set_chip(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        host_req = 1'b0; host_we = 1'b0; host_be = 2'b00; host_addr = '0; host_wdata = '0;
        sram_din = '0;
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = 16'($urandom);
            exp_mem[i]  = sram_mem[i];
        end
        model_reset();
        last_ack_cyc = 0;

        repeat (3) step();
        check_eq("rst_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'hF);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_dout", 32'(sram_dout), 32'd0);
        check_eq("rst_hrdata", 32'(host_rdata), 32'd0);
        check_eq("rst_ack", 32'(host_ack), 32'd0);
        check_eq("rst_starved", 32'(host_starved), 32'd0);
        check_eq("rst_crdata", 32'(chip_rdata), 32'd0);
        #2 _reset = 1'b1;
        step();

        // host write, uncontested
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b11;
        host_addr = 22'h12345; host_wdata = 16'hA55A;
        s = cyc;
        run_slot();
        check_eq("t1_ack_lat", 32'(last_ack_cyc - s), 32'd4);
        check_eq("t1_mem", 32'(sram_mem[5]), 32'hA55A);

        // read back the same word (first slot blocked by ack pending)
        host_we = 1'b0;
        host_until_ack("t2_grant");
        check_eq("t2_rdata", 32'(host_rdata), 32'hA55A);

        // chip read collides with host request: chip first, host next slot
        run_slot();
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b11;
        host_addr = BASE + 22'd2; host_wdata = 16'h0F0F;
        set_chip(1'b1, 1'b1, 1'b0, 1'b0, 22'h12345, 16'h0000);
        s = cyc;
        run_slot();
        check_eq("t3_chip_won", 32'(last_win), 32'd1);
        check_eq("t3_crdata", 32'(chip_rdata), 32'hA55A);
        set_chip(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        run_slot();
        check_eq("t3_ack_lat", 32'(last_ack_cyc - s), 32'd8);
        host_req = 1'b0;

        // starvation: chip reads every slot while the host waits
        host_req = 1'b1; host_we = 1'b0; host_addr = BASE + 22'd3;
        for (int k = 1; k <= WAIT_LIMIT + 1; k++) begin
            set_chip(1'b1, 1'b1, 1'b0, 1'b0, BASE + 22'(k % 16), 16'h0000);
            run_slot();
            if (k == WAIT_LIMIT - 1) check_eq("t4_not_starved", 32'(host_starved), 32'd0);
            if (k == WAIT_LIMIT)     check_eq("t4_starved", 32'(host_starved), 32'd1);
        end
        check_eq("t4_saturated", 32'(host_starved), 32'd1);
        set_chip(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        run_slot();
        check_eq("t4_granted", 32'(last_win), 32'd2);
        check_eq("t4_cleared", 32'(host_starved), 32'd0);
        host_req = 1'b0;

        // upper-byte-only host write
        old = sram_mem[6];
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b10;
        host_addr = BASE + 22'd6; host_wdata = 16'h1234;
        host_until_ack("t5_grant");
        check_eq("t5_bytewr", 32'(sram_mem[6]), 32'({8'h12, old[7:0]}));

        // host write with no byte enables: slot used, ack issued, no we
        old = sram_mem[7];
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b00;
        host_addr = BASE + 22'd7; host_wdata = ~old;
        host_until_ack("t6_grant");
        check_eq("t6_unchanged", 32'(sram_mem[7]), 32'(old));

        // reset asserted during Q2 of a host write
        run_slot();
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b11;
        host_addr = BASE + 22'd8; host_wdata = 16'h5AA5;
        set_phase(1); step();
        set_phase(2); step();
        check_eq("t7_pre_we", 32'(_sram_we), 32'd0);
        #2 _reset = 1'b0;
        #1;
        check_eq("t7_rst_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'hF);
        check_eq("t7_rst_ack", 32'(host_ack), 32'd0);
        #2 _reset = 1'b1;
        model_reset();
        set_phase(3); step();
        set_phase(0); step();
        check_eq("t7_no_ack", 32'(host_ack), 32'd0);
        check_eq("t7_idle", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'hF);
        run_slot();
        check_eq("t7_completed", 32'(last_win), 32'd2);
        host_req = 1'b0;
        run_slot();

        // c1/c3 stuck with no Q1: nothing may be granted
        host_new();
        set_phase(0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("t8_stuck_strobes", 32'({_sram_we, _sram_oe, _sram_bhe, _sram_ble}), 32'hF);
            check_eq("t8_stuck_ack", 32'(host_ack), 32'd0);
        end
        host_until_ack("t8_grant");

        // randomized traffic with varying chipset load
        host_req = 1'b0;
        for (int n = 0; n < 300; n++) begin
            chip_pct = (n < 100) ? 30 : (n < 200) ? 95 : 50;
            if (last_win == 2) begin
                if ($urandom_range(0, 2) == 0) host_new();
                else host_req = 1'b0;
            end else if (!host_req && $urandom_range(0, 2) == 0) begin
                host_new();
            end
            kind = int'($urandom_range(0, 3));
            set_chip(1'($urandom_range(0, 99) < chip_pct), kind == 1,
                     kind >= 2 && 1'($urandom), kind >= 2 && 1'($urandom),
                     BASE + 22'($urandom_range(0, 15)), 16'($urandom));
            run_slot();
        end

        for (int i = 0; i < 16; i++) check_eq("mem_final", 32'(sram_mem[i]), 32'(exp_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
